// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor with saturating counters, optional gshare
// indexing, and resolved-branch / misprediction statistics.
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int ENTRIES  = 32,
  parameter int CNT_BITS = 2,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bp_enable,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  output logic                pred_taken,
  output logic                pred_hit,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  input  logic                mispredict,
  input  logic                clear_stats,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] WEAK_T  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] WEAK_N  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  function automatic logic [CNT_BITS-1:0] sat_inc_cnt(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec_cnt(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic                valid_mem [ENTRIES];
  logic [TAG_W-1:0]    tag_mem   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_mem   [ENTRIES];
  logic [IDX-1:0]      ghr;
  logic [IDX-1:0]      hist;

  logic [IDX-1:0]   gidx, cidx;
  logic [TAG_W-1:0] gtag, ctag;
  logic             upd, upd_hit;
  logic [CNT_BITS-1:0] cnt_next;
  logic             unused_pc_bits;

  // History only participates in indexing when gshare is selected.
  assign hist = (MODE == 1) ? ghr : '0;
  assign gidx = pc_guess[IDX+1:2] ^ hist;
  assign cidx = pc_check[IDX+1:2] ^ hist;
  assign gtag = pc_guess[PC_WIDTH-1:IDX+2];
  assign ctag = pc_check[PC_WIDTH-1:IDX+2];
  assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

  assign pred_hit   = bp_enable & is_br_guess & valid_mem[gidx] & (tag_mem[gidx] == gtag);
  assign pred_taken = pred_hit & cnt_mem[gidx][CNT_BITS-1];

  assign upd     = bp_enable & is_br_check;
  assign upd_hit = valid_mem[cidx] & (tag_mem[cidx] == ctag);

  always_comb begin
    cnt_next = br_taken_check ? WEAK_T : WEAK_N;
    if (upd_hit)
      cnt_next = br_taken_check ? sat_inc_cnt(cnt_mem[cidx]) : sat_dec_cnt(cnt_mem[cidx]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i] <= 1'b0;
        cnt_mem[i]   <= '0;
      end
      ghr <= '0;
    end else if (upd) begin
      valid_mem[cidx] <= 1'b1;
      cnt_mem[cidx]   <= cnt_next;
      if (MODE == 1)
        ghr <= IDX'({ghr, br_taken_check});
    end
  end

  // Tags are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd && !upd_hit)
      tag_mem[cidx] <= ctag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (clear_stats) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd) begin
      br_count      <= sat_inc32(br_count, 1'b1);
      mispred_count <= sat_inc32(mispred_count, mispredict);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Drives a bimodal and a gshare predictor (8 entries, 2-bit counters) with the
// same stimulus and compares both against a table-level reference model.
module tb_branch_predictor;

  logic        clk, rst, bp_enable, is_br_guess, is_br_check, br_taken_check;
  logic        mispredict, clear_stats;
  logic [31:0] pc_guess, pc_check;
  logic        pt0, ph0, pt1, ph1;
  logic [31:0] bc0, mc0, bc1, mc1;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, index [m] = MODE
  bit      mv   [2][8];
  int      mtag [2][8];
  int      mcnt [2][8];
  int      mghr [2];
  longint  mbr  [2];
  longint  mmis [2];

  branch_predictor #(.PC_WIDTH(32), .ENTRIES(8), .CNT_BITS(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bp_enable(bp_enable), .pc_guess(pc_guess),
    .is_br_guess(is_br_guess), .pred_taken(pt0), .pred_hit(ph0), .pc_check(pc_check),
    .is_br_check(is_br_check), .br_taken_check(br_taken_check), .mispredict(mispredict),
    .clear_stats(clear_stats), .br_count(bc0), .mispred_count(mc0));

  branch_predictor #(.PC_WIDTH(32), .ENTRIES(8), .CNT_BITS(2), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bp_enable(bp_enable), .pc_guess(pc_guess),
    .is_br_guess(is_br_guess), .pred_taken(pt1), .pred_hit(ph1), .pc_check(pc_check),
    .is_br_check(is_br_check), .br_taken_check(br_taken_check), .mispredict(mispredict),
    .clear_stats(clear_stats), .br_count(bc1), .mispred_count(mc1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int midx(int m, logic [31:0] pc);
    int base = int'((pc >> 2) % 8);
    return (m == 1) ? ((base ^ mghr[m]) % 8) : base;
  endfunction

  function automatic int mtagof(logic [31:0] pc);
    return int'(pc >> 5);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        mv[m][i] = 0; mcnt[m][i] = 0; mtag[m][i] = 0;
      end
      mghr[m] = 0; mbr[m] = 0; mmis[m] = 0;
    end
  endtask

  task automatic check_lookup();
    for (int m = 0; m < 2; m++) begin
      int  i   = midx(m, pc_guess);
      bit  hit = bp_enable && is_br_guess && mv[m][i] && (mtag[m][i] == mtagof(pc_guess));
      bit  tk  = hit && (mcnt[m][i] >= 2);
      chk(m ? "gs_hit" : "bi_hit", m ? 32'(ph1) : 32'(ph0), 32'(hit));
      chk(m ? "gs_taken" : "bi_taken", m ? 32'(pt1) : 32'(pt0), 32'(tk));
    end
  endtask

  task automatic check_stats();
    chk("bi_br_count", bc0, 32'(mbr[0]));
    chk("bi_mispred_count", mc0, 32'(mmis[0]));
    chk("gs_br_count", bc1, 32'(mbr[1]));
    chk("gs_mispred_count", mc1, 32'(mmis[1]));
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (bp_enable && is_br_check) begin
        int i = midx(m, pc_check);
        int t = mtagof(pc_check);
        if (mv[m][i] && mtag[m][i] == t)
          mcnt[m][i] = br_taken_check ? ((mcnt[m][i] + 1 > 3) ? 3 : mcnt[m][i] + 1)
                                      : ((mcnt[m][i] - 1 < 0) ? 0 : mcnt[m][i] - 1);
        else begin
          mv[m][i] = 1; mtag[m][i] = t; mcnt[m][i] = br_taken_check ? 2 : 1;
        end
        if (m == 1) mghr[m] = ((mghr[m] * 2) + int'(br_taken_check)) % 8;
      end
      if (clear_stats) begin
        mbr[m] = 0; mmis[m] = 0;
      end else if (bp_enable && is_br_check) begin
        if (mbr[m] < 64'hFFFF_FFFF) mbr[m]++;
        if (mispredict && mmis[m] < 64'hFFFF_FFFF) mmis[m]++;
      end
    end
  endtask

  // One clock: inputs applied after the falling edge, lookup checked before the
  // rising edge, statistics checked just after it.
  task automatic step(bit en, logic [31:0] pg, bit ig, logic [31:0] pcc, bit ic,
                      bit tk, bit mp, bit clr);
    bp_enable = en; pc_guess = pg; is_br_guess = ig; pc_check = pcc;
    is_br_check = ic; br_taken_check = tk; mispredict = mp; clear_stats = clr;
    #1 check_lookup();
    @(posedge clk);
    model_edge();
    #1 check_stats();
    @(negedge clk);
  endtask

  task automatic upd(logic [31:0] pc, bit tk, bit mp);
    step(1, pc, 1, pc, 1, tk, mp, 0);
  endtask

  task automatic look(logic [31:0] pc);
    step(1, pc, 1, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1 model_reset();
    check_lookup();
    check_stats();
    @(negedge clk);
    rst = 1'b1;
    #1 check_lookup();
    check_stats();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; bp_enable = 0; pc_guess = 0; is_br_guess = 0; pc_check = 0;
    is_br_check = 0; br_taken_check = 0; mispredict = 0; clear_stats = 0;
    model_reset();
    @(negedge clk);
    pc_guess = 32'h100; is_br_guess = 1; bp_enable = 1;
    do_reset();

    // Cold lookup, then train up to saturation and back down.
    look(32'h100);
    upd(32'h100, 1, 0);
    look(32'h100);
    repeat (3) upd(32'h100, 1, 0);
    upd(32'h100, 0, 1);
    look(32'h100);
    upd(32'h100, 0, 0);
    look(32'h100);

    // Same-cycle lookup and update see the pre-update counter.
    step(1, 32'h100, 1, 32'h100, 1, 1, 0, 0);
    look(32'h100);

    // Aliasing at index 0 with a different tag overwrites the entry.
    upd(32'h100, 1, 0);
    upd(32'h120, 0, 0);
    look(32'h100);
    look(32'h120);

    // Statistics with clear priority, and bypass leaving everything alone.
    do_reset();
    upd(32'h104, 1, 1);
    upd(32'h108, 0, 0);
    upd(32'h10c, 1, 1);
    upd(32'h104, 1, 0);
    upd(32'h108, 1, 0);
    step(1, 32'h104, 1, 32'h104, 1, 1, 1, 1);
    upd(32'h104, 1, 1);
    step(0, 32'h104, 1, 32'h104, 1, 0, 1, 0);
    step(0, 32'h200, 1, 32'h200, 1, 1, 1, 0);
    look(32'h200);

    // Gshare history T,N,T then lookups relying on ghr = 3'b101.
    do_reset();
    upd(32'h100, 1, 0);
    upd(32'h100, 0, 0);
    upd(32'h100, 1, 0);
    look(32'h100);
    look(32'h114);

    // Asynchronous reset asserted mid-update discards it.
    bp_enable = 1; pc_check = 32'h300; is_br_check = 1; br_taken_check = 1;
    pc_guess = 32'h300;
    #2 rst = 1'b0;
    #1 model_reset();
    check_lookup();
    check_stats();
    @(negedge clk);
    rst = 1'b1;
    is_br_check = 0;
    @(negedge clk);
    look(32'h300);

    // Randomized traffic over a small PC set so entries alias and saturate.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pg = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      logic [31:0] pc = ($urandom_range(0, 4) == 0) ? pg : ($urandom_range(0, 127) << 2);
      bit en  = ($urandom_range(0, 9) != 0);
      bit clr = en && ($urandom_range(0, 49) == 0);
      step(en, pg, $urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32; instruction address width.
REQ-002 SHALL have parameter ENTRIES, default 32; table depth, power of two, 2..1024; IDX = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_BITS, default 2; saturating counter width, 1..4.
REQ-004 SHALL have parameter MODE, default 0; 0 = bimodal, 1 = gshare (index XOR global history).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port bp_enable  input  1  1 = predict and train; 0 = predictor bypassed.
REQ-008 SHALL have port pc_guess  input  PC_WIDTH  PC of the fetch-stage instruction being predicted.
REQ-009 SHALL have port is_br_guess  input  1  fetch-stage instruction is a conditional branch.
REQ-010 SHALL have port pred_taken  output  1  prediction for pc_guess.
REQ-011 SHALL have port pred_hit  output  1  lookup matched a valid tagged entry.
REQ-012 SHALL have port pc_check  input  PC_WIDTH  PC of the execute-stage resolved branch.
REQ-013 SHALL have port is_br_check  input  1  execute-stage instruction is a conditional branch (update strobe).
REQ-014 SHALL have port br_taken_check  input  1  resolved outcome.
REQ-015 SHALL have port mispredict  input  1  resolved outcome differed from prediction.
REQ-016 SHALL have port clear_stats  input  1  synchronous clear of statistics counters.
REQ-017 SHALL have port br_count  output  32  resolved branches counted.
REQ-018 SHALL have port mispred_count  output  32  mispredictions counted.

Function
REQ-019 SHALL compute index = pc[IDX+1:2] in MODE 0, pc[IDX+1:2] XOR ghr[IDX-1:0] in MODE 1; tag = pc[PC_WIDTH-1:IDX+2].
REQ-020 SHALL hold per entry: valid (1b), tag, counter (CNT_BITS); ghr is IDX bits, present only in MODE 1.
REQ-021 SHALL produce lookup combinationally (0-cycle): pred_hit = bp_enable & is_br_guess & valid & tag match; pred_taken = pred_hit & counter MSB.
REQ-022 SHALL force pred_taken = 0, pred_hit = 0 when bp_enable = 0, is_br_guess = 0, or on a miss.
REQ-023 SHALL perform an update on a rising edge when bp_enable & is_br_check = 1, using pc_check and pre-edge ghr.
REQ-024 On update hit: taken -> counter+1 saturating at 2^CNT_BITS-1; not taken -> counter-1 saturating at 0.
REQ-025 On update miss (invalid or tag mismatch): set valid = 1, write tag, counter = 2^(CNT_BITS-1) if taken, else 2^(CNT_BITS-1)-1 (weak state); no eviction policy beyond direct-mapped overwrite.
REQ-026 In MODE 1, ghr SHALL shift left by one on each update, inserting br_taken_check at bit 0.
REQ-027 Simultaneous lookup and update of the same entry SHALL return the pre-update state (no bypass).
REQ-028 On each update br_count SHALL increment by 1; mispred_count SHALL increment by 1 when mispredict = 1; both saturate at 0xFFFFFFFF.
REQ-029 clear_stats = 1 SHALL zero both statistics counters on that edge, taking priority over a same-cycle increment.
REQ-030 With bp_enable = 0, no table, ghr or statistics state SHALL change.

Reset
REQ-031 rst = 0 SHALL asynchronously clear all valid bits, counters, ghr, br_count and mispred_count to 0.
REQ-032 Outputs SHALL read pred_taken = 0, pred_hit = 0, br_count = 0, mispred_count = 0 while in reset and after release.
REQ-033 Reset asserted mid-update SHALL discard the update; first post-reset lookup SHALL miss.

Verification (ENTRIES=8, CNT_BITS=2, MODE=0 unless noted)
REQ-034 Cold lookup pc_guess=0x100, is_br_guess=1 after reset -> pred_hit=0, pred_taken=0.
REQ-035 Update pc_check=0x100 taken once -> counter=2, lookup 0x100 gives pred_hit=1, pred_taken=1; three more taken -> counter saturates at 3; then two not-taken -> counter=1, pred_taken=0.
REQ-036 Alias: train 0x100 taken, then update 0x120 (same index 0, tag 9) not-taken -> lookup 0x100 misses, lookup 0x120 hits with pred_taken=0.
REQ-037 Same-cycle lookup/update on 0x100 with counter=1, outcome taken -> pred_taken=0 that cycle, 1 next cycle.
REQ-038 Stats: 5 updates with mispredict asserted on 2, then clear_stats with a concurrent update -> br_count=5, mispred_count=2, then both 0; bp_enable=0 updates leave counts unchanged.
REQ-039 MODE=1: updates taken, not-taken, taken -> ghr=3'b101; subsequent lookup at pc 0x100 indexes entry 5.
